// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD block-channel arbiter.
// TIMEOUT_MAX is the default watchdog limit used when SD_ARB_TIMEOUT_EN is defined.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2
  } state_e;

  localparam int          SD_LBA_W    = 32;
  localparam int          SD_BUF_AW   = 9;
  localparam logic [23:0] TIMEOUT_MAX = 24'hFFFFFF;

endpackage

// File: rtl/sd_access_arbiter_rr_pick.sv
// Combinational round-robin picker: the first pending bit at or after ptr, wrapping.
module rr_pick #(
  parameter int NCLI = 2,
  parameter int IDW  = 2
) (
  input  logic [NCLI-1:0] pend,
  input  logic [IDW-1:0]  ptr,
  output logic            vld,
  output logic [IDW-1:0]  idx
);

  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int k = 0; k < NCLI; k++) begin
      int c;
      c = (int'(ptr) + k) % NCLI;
      for (int j = 0; j < NCLI; j++) begin
        if (!vld && (j == c) && pend[j]) begin
          vld = 1'b1;
          idx = IDW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/sd_access_arbiter.sv
// Shares the I/O block's single SD sector channel between NCLI clients with round-robin fairness.
// Optional watchdog on GRANT/XFER enabled by defining SD_ARB_TIMEOUT_EN (adds the timeout_err port).
module sd_access_arbiter
  import sd_arb_pkg::*;
#(
  parameter int NCLI = 2,
  parameter int IDW  = 2
`ifdef SD_ARB_TIMEOUT_EN
  , parameter logic [23:0] TIMEOUT_LIMIT = TIMEOUT_MAX
`endif
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic [32*NCLI-1:0]   cli_lba,
  input  logic [NCLI-1:0]      cli_rd,
  input  logic [NCLI-1:0]      cli_wr,
  output logic [NCLI-1:0]      cli_ack,
  output logic [NCLI-1:0]      cli_done,
  output logic [NCLI-1:0]      cli_buff_wr,
  input  logic [8*NCLI-1:0]    cli_buff_din,
  output logic [SD_LBA_W-1:0]  sd_lba,
  output logic                 sd_rd,
  output logic                 sd_wr,
  input  logic                 sd_ack,
  input  logic                 sd_buff_wr,
  output logic [7:0]           sd_buff_din,
  output logic [IDW-1:0]       owner,
  output logic                 busy
`ifdef SD_ARB_TIMEOUT_EN
  , output logic               timeout_err
`endif
);

  state_e              state_q, state_d;
  logic [IDW-1:0]      owner_q, owner_d;
  logic [IDW-1:0]      rr_q, rr_d;
  logic [SD_LBA_W-1:0] lba_q, lba_d;
  logic                dir_q, dir_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                busy_q, busy_d;
  logic [NCLI-1:0]     done_q, done_d;

  logic                pick_vld;
  logic [IDW-1:0]      pick_idx;
  logic [SD_LBA_W-1:0] pick_lba;
  logic                pick_rd, pick_wr;
  logic [NCLI-1:0]     owner_oh;
  logic [IDW-1:0]      owner_nxt;

`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0] cnt_q, cnt_d;
  logic        to_q, to_d;
`endif

  rr_pick #(.NCLI(NCLI), .IDW(IDW)) u_pick (
    .pend (cli_rd | cli_wr),
    .ptr  (rr_q),
    .vld  (pick_vld),
    .idx  (pick_idx)
  );

  always_comb begin
    pick_lba = '0;
    pick_rd  = 1'b0;
    pick_wr  = 1'b0;
    owner_oh = '0;
    for (int i = 0; i < NCLI; i++) begin
      if (pick_idx == IDW'(i)) begin
        pick_lba = cli_lba[32*i +: 32];
        pick_rd  = cli_rd[i];
        pick_wr  = cli_wr[i];
      end
      if (owner_q == IDW'(i)) owner_oh[i] = 1'b1;
    end
    owner_nxt = (owner_q == IDW'(NCLI-1)) ? '0 : owner_q + IDW'(1);
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    lba_d   = lba_q;
    dir_d   = dir_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    done_d  = '0;
`ifdef SD_ARB_TIMEOUT_EN
    to_d    = to_q;
`endif
    unique case (state_q)
      IDLE: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
        // A high sd_ack here is a transfer we no longer own; let it finish first.
        if (pick_vld && !sd_ack) begin
          owner_d = pick_idx;
          lba_d   = pick_lba;
          dir_d   = pick_wr & ~pick_rd;
          busy_d  = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (sd_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = XFER;
        end else begin
          rd_d = ~dir_q;
          wr_d = dir_q;
        end
      end
      XFER: begin
        if (!sd_ack) begin
          done_d  = owner_oh;
          rr_d    = owner_nxt;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef SD_ARB_TIMEOUT_EN
          to_d    = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef SD_ARB_TIMEOUT_EN
    // Counter restarts on every state entry; abort fires on the LIMIT-th cycle in a state.
    cnt_d = (state_q == IDLE || state_d != state_q) ? 24'd0 : cnt_q + 24'd1;
    if (state_q != IDLE && cnt_q == TIMEOUT_LIMIT - 24'd1) begin
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      done_d  = owner_oh;
      rr_d    = owner_nxt;
      busy_d  = 1'b0;
      to_d    = 1'b1;
      cnt_d   = 24'd0;
      state_d = IDLE;
    end
`endif
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      lba_q   <= '0;
      dir_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= '0;
`ifdef SD_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      lba_q   <= lba_d;
      dir_q   <= dir_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SD_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  // Buffer steering is combinational so the owner sees strobes with no added latency.
  always_comb begin
    cli_ack     = '0;
    cli_buff_wr = '0;
    sd_buff_din = '0;
    if (state_q == XFER) begin
      for (int i = 0; i < NCLI; i++) begin
        if (owner_q == IDW'(i)) begin
          cli_ack[i]     = sd_ack;
          cli_buff_wr[i] = sd_buff_wr;
          sd_buff_din    = cli_buff_din[8*i +: 8];
        end
      end
    end
  end

  assign cli_done = done_q;
  assign sd_lba   = lba_q;
  assign sd_rd    = rd_q;
  assign sd_wr    = wr_q;
  assign owner    = owner_q;
  assign busy     = busy_q;
`ifdef SD_ARB_TIMEOUT_EN
  assign timeout_err = to_q;
`endif

endmodule

// File: doc/sd_access_arbiter.md
Name: sd_access_arbiter

Overview:
- Shares the single SD block-level channel of the ARM I/O block between NCLI virtual-drive clients, e.g. the TRD/Beta-disk controller and the DivMMC/esxDOS card.
- Sits between the clients and the I/O block's sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_* signals. The I/O block is treated as the single resource.
- Latches one client request, runs the rd/wr-to-ack handshake, steers buffer traffic to the owner, then releases the channel with round-robin fairness.

Parameters:
- NCLI, 2, number of clients (2..4)
- IDW, 2, client-index width; must be at least clog2(NCLI)

Ports:
- clk_sys  in  1  system clock; the I/O block's sd_* side runs in this domain
- reset_n  in  1  asynchronous active-low reset
- cli_lba  in  32*NCLI  per-client sector LBA; slice i = [32*i +: 32]
- cli_rd  in  NCLI  per-client read request level
- cli_wr  in  NCLI  per-client write request level
- cli_ack  out  NCLI  per-client copy of sd_ack, owner only
- cli_done  out  NCLI  one-cycle pulse when the owner's sector completes
- cli_buff_wr  out  NCLI  sd_buff_wr, gated to the owner
- cli_buff_din  in  8*NCLI  per-client buffer read data (write-to-card direction)
- sd_lba  out  32  LBA toward the I/O block
- sd_rd  out  1  read request toward the I/O block
- sd_wr  out  1  write request toward the I/O block
- sd_ack  in  1  transfer-active from the I/O block
- sd_buff_wr  in  1  buffer write strobe from the I/O block
- sd_buff_din  out  8  muxed owner buffer data toward the I/O block
- owner  out  IDW  current or last grant index
- busy  out  1  high from GRANT until return to IDLE

Behaviour:
- Reset: state IDLE. sd_rd=0, sd_wr=0, sd_lba=0, cli_ack=0, cli_done=0, cli_buff_wr=0, owner=0, busy=0, rr pointer=0, sd_buff_din=0.
- Clients broadcast-read sd_buff_addr and sd_buff_dout directly from the I/O block; the arbiter does not route them.
- States:
  - IDLE: compute a pending vector p[i]=cli_rd[i]|cli_wr[i]. Grant the first set bit at or after the rr pointer, wrapping. On grant: owner<=i; sd_lba<=cli_lba[i]; latch dir. dir=write only if cli_wr[i]; if rd and wr are both set, read wins. Go to GRANT, busy<=1.
  - GRANT: sd_rd<=~dir, sd_wr<=dir. Wait for sd_ack=1, then go to XFER and drop sd_rd/sd_wr on the same edge.
  - XFER: cli_ack[owner]=sd_ack, combinational. cli_buff_wr[owner]=sd_buff_wr. sd_buff_din=cli_buff_din[owner]. On sd_ack=0: cli_done[owner]<=1 for 1 cycle, rr<=owner+1 (wrapping at NCLI), go to IDLE.
  - On the IDLE return cycle busy<=0. The earliest next grant is the following cycle.
- Latency: request to sd_rd/sd_wr assertion is 2 clk_sys cycles (IDLE→GRANT, GRANT drives).
- sd_lba is stable from GRANT until IDLE. The LBA is captured once; later cli_lba changes are ignored.
- Client protocol: a client holds rd/wr until its cli_ack rises, then deasserts. A request still high at XFER exit is treated as a new request and re-arbitrated.
- Non-owners always see cli_ack=0 and cli_buff_wr=0.
- sd_buff_din is 0 outside XFER.
- Owner drops its request during GRANT: the transfer proceeds anyway. The I/O block is already committed.
- sd_ack already high in IDLE (stale transfer): no grant until sd_ack=0.
- Simultaneous requests: exactly one grant per IDLE cycle.
- Reset mid-XFER: outputs return to reset values immediately. The I/O block sees sd_rd/sd_wr=0 and completes on its own; stray sd_buff_wr is dropped.
- NCLI=1 degenerates to a pass-through with 2-cycle request latency.

Optional Feature:
- Macro: SD_ARB_TIMEOUT_EN
- With the macro: a 24-bit counter runs in GRANT and XFER and clears on each state entry.
  - At 0xFFFFFF: drop sd_rd/sd_wr and pulse cli_done[owner].
  - Set sticky timeout_err, a 1-bit output port present only with the macro; cleared by reset or the next successful done.
  - rr advances; go to IDLE.
- Without the macro: no counter and no timeout_err port. GRANT and XFER wait indefinitely.

Decomposition:
- Shared package sd_arb_pkg: state enum (IDLE, GRANT, XFER), SD_LBA_W=32, SD_BUF_AW=9, TIMEOUT_MAX.
- One sub-module, rr_pick: combinational round-robin priority encoder.
  - Inputs: pending vector, rr pointer.
  - Outputs: valid, index.

Test Plan:
- Single read, NCLI=2: cli_rd[1]=1, cli_lba[63:32]=0x00001234.
  - Required: sd_rd=1 two cycles later with sd_lba=0x1234.
  - BFM sd_ack high for 512 sd_buff_wr strobes. Required: cli_buff_wr[1] sees 512 strobes and cli_buff_wr[0] sees 0.
  - Required: cli_done[1] pulses once; owner=1.
- Write path: cli_wr[0]=1, client 0 returns din=addr[7:0].
  - Required: sd_wr=1.
  - Required: sd_buff_din equals addr low byte throughout XFER; cli_ack[1] stays 0.
- Contention, rr=0: cli_rd=2'b11 held.
  - Required grant order is 0,1,0,1 across four transfers.
  - Required: each sd_rd assertion follows the previous done by ≥1 IDLE cycle.
- Both rd and wr set on client 0, lba=7:
  - Required: read issued (sd_rd=1, sd_wr=0); sd_lba=7.
- Reset mid-XFER: assert reset_n=0 at the 100th strobe.
  - Required: sd_rd=sd_wr=0, cli_ack=0 and busy=0 in the same cycle; no cli_done.
  - After release, a new cli_rd[0] is granted normally.
- With SD_ARB_TIMEOUT_EN and TIMEOUT_MAX forced to 16: request with sd_ack never asserted.
  - Required: at cycle 16 after GRANT entry, sd_rd drops, cli_done pulses and timeout_err=1.
